ex_stage_unpack_hazard: RTL and testbench

//  EX-stage reader of the 116-bit ID/EX pipeline bus: splits it into named fields for the ALU,

---
 rtl/ex_stage_unpack_hazard_if.sv | 45 ++++
 rtl/ex_stage_unpack_hazard.sv | 99 +++++++++
 tb/tb_ex_stage_unpack_hazard.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/ex_stage_unpack_hazard_if.sv
// ID/EX bus, ID register operands and the hazard-unit enables/counters seen by the EX stage.
interface ex_stage_unpack_hazard_if #(parameter int CNT_W = 16);
  logic [115:0]     id_ex_bus;
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_uses_rs2;
  logic             branch_taken;

  logic             func7;
  logic [2:0]       func3;
  logic             alu_src;
  logic             branch;
  logic             jalr;
  logic             jal;
  logic             mem_read;
  logic             mem_write;
  logic             mem_to_reg;
  logic             reg_write;
  logic [2:0]       alu_op;
  logic [4:0]       rd;
  logic [31:0]      rd2;
  logic [31:0]      rd1;
  logic [31:0]      imm;

  logic             pc_enable;
  logic             ifid_enable;
  logic             ifid_flush;
  logic             idex_bubble;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output id_ex_bus, id_rs1, id_rs2, id_uses_rs2, branch_taken,
    input  func7, func3, alu_src, branch, jalr, jal, mem_read, mem_write,
           mem_to_reg, reg_write, alu_op, rd, rd2, rd1, imm,
           pc_enable, ifid_enable, ifid_flush, idex_bubble, stall_count, flush_count
  );

  modport slave (
    input  id_ex_bus, id_rs1, id_rs2, id_uses_rs2, branch_taken,
    output func7, func3, alu_src, branch, jalr, jal, mem_read, mem_write,
           mem_to_reg, reg_write, alu_op, rd, rd2, rd1, imm,
           pc_enable, ifid_enable, ifid_flush, idex_bubble, stall_count, flush_count
  );
endinterface

// File: rtl/ex_stage_unpack_hazard.sv
// Unpacks the ID/EX bus (zero latency) and drives load-use stall / redirect flush enables.
// One-cycle stall per load-use pair; redirect outranks stall; state changes on negedge clk.
module ex_stage_unpack_hazard #(
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  ex_stage_unpack_hazard_if.slave  ex
);

  typedef struct packed {
    logic        func7;
    logic [2:0]  func3;
    logic        alu_src;
    logic        branch;
    logic        jalr;
    logic        jal;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        reg_write;
    logic [2:0]  alu_op;
    logic [4:0]  rd;
    logic [31:0] rd2;
    logic [31:0] rd1;
    logic [31:0] imm;
  } id_ex_t;

  typedef enum logic {RUN, LU_STALL} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  id_ex_t           f;
  state_t           state, state_nxt;
  logic             redirect, load_use;
  logic             stall_inc, flush_inc;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  assign f = id_ex_t'(ex.id_ex_bus);

  assign ex.func7      = f.func7;
  assign ex.func3      = f.func3;
  assign ex.alu_src    = f.alu_src;
  assign ex.branch     = f.branch;
  assign ex.jalr       = f.jalr;
  assign ex.jal        = f.jal;
  assign ex.mem_read   = f.mem_read;
  assign ex.mem_write  = f.mem_write;
  assign ex.mem_to_reg = f.mem_to_reg;
  assign ex.reg_write  = f.reg_write;
  assign ex.alu_op     = f.alu_op;
  assign ex.rd         = f.rd;
  assign ex.rd2        = f.rd2;
  assign ex.rd1        = f.rd1;
  assign ex.imm        = f.imm;

  assign redirect = f.jal | f.jalr | (f.branch & ex.branch_taken);
  assign load_use = f.mem_read & (f.rd != 5'd0) &
                    ((f.rd == ex.id_rs1) | (ex.id_uses_rs2 & (f.rd == ex.id_rs2)));

  always_comb begin
    state_nxt      = RUN;
    ex.pc_enable   = 1'b1;
    ex.ifid_enable = 1'b1;
    ex.ifid_flush  = 1'b0;
    ex.idex_bubble = 1'b0;
    stall_inc      = 1'b0;
    flush_inc      = 1'b0;
    // A redirect squashes the ID instruction, so any pending load-use stall is moot.
    if (redirect) begin
      ex.ifid_flush  = 1'b1;
      ex.idex_bubble = 1'b1;
      flush_inc      = 1'b1;
    end else if (state == RUN && load_use) begin
      ex.pc_enable   = 1'b0;
      ex.ifid_enable = 1'b0;
      ex.idex_bubble = 1'b1;
      stall_inc      = 1'b1;
      state_nxt      = LU_STALL;
    end
  end

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      state     <= RUN;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (stall_inc && stall_cnt != CNT_MAX) stall_cnt <= stall_cnt + CNT_ONE;
      if (flush_inc && flush_cnt != CNT_MAX) flush_cnt <= flush_cnt + CNT_ONE;
    end
  end

  assign ex.stall_count = stall_cnt;
  assign ex.flush_count = flush_cnt;

endmodule

// File: tb/tb_ex_stage_unpack_hazard.sv
// Directed bench: a wide-counter and a 2-bit-counter instance share stimulus and a reference model.
module tb_ex_stage_unpack_hazard;
  localparam int W_A = 16;
  localparam int W_B = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [115:0] bus = '0;
  logic [4:0]   rs1 = '0, rs2 = '0;
  logic         uses = 1'b0, taken = 1'b0;

  ex_stage_unpack_hazard_if #(.CNT_W(W_A)) if_a ();
  ex_stage_unpack_hazard_if #(.CNT_W(W_B)) if_b ();

  assign if_a.id_ex_bus = bus;   assign if_b.id_ex_bus = bus;
  assign if_a.id_rs1 = rs1;      assign if_b.id_rs1 = rs1;
  assign if_a.id_rs2 = rs2;      assign if_b.id_rs2 = rs2;
  assign if_a.id_uses_rs2 = uses; assign if_b.id_uses_rs2 = uses;
  assign if_a.branch_taken = taken; assign if_b.branch_taken = taken;

  ex_stage_unpack_hazard #(.CNT_W(W_A)) dut_a (.clk(clk), .reset(reset), .ex(if_a));
  ex_stage_unpack_hazard #(.CNT_W(W_B)) dut_b (.clk(clk), .reset(reset), .ex(if_b));

  logic [115:0] flds_a, flds_b;
  logic [3:0]   ctrl_a, ctrl_b;
  assign flds_a = {if_a.func7, if_a.func3, if_a.alu_src, if_a.branch, if_a.jalr, if_a.jal,
                   if_a.mem_read, if_a.mem_write, if_a.mem_to_reg, if_a.reg_write,
                   if_a.alu_op, if_a.rd, if_a.rd2, if_a.rd1, if_a.imm};
  assign flds_b = {if_b.func7, if_b.func3, if_b.alu_src, if_b.branch, if_b.jalr, if_b.jal,
                   if_b.mem_read, if_b.mem_write, if_b.mem_to_reg, if_b.reg_write,
                   if_b.alu_op, if_b.rd, if_b.rd2, if_b.rd1, if_b.imm};
  assign ctrl_a = {if_a.pc_enable, if_a.ifid_enable, if_a.ifid_flush, if_a.idex_bubble};
  assign ctrl_b = {if_b.pc_enable, if_b.ifid_enable, if_b.ifid_flush, if_b.idex_bubble};

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: a "just stalled" flag and unbounded event counts.
  bit m_stall = 1'b0;
  int m_stalls = 0;
  int m_flushes = 0;

  function automatic bit m_redirect();
    return bus[108] | bus[109] | (bus[110] & taken);
  endfunction

  function automatic bit m_load_use();
    logic [4:0] r;
    r = bus[100:96];
    return !m_stall && bus[107] && (r != 5'd0) && ((r == rs1) || (uses && r == rs2));
  endfunction

  function automatic int sat(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  always @(negedge clk or negedge reset) begin
    if (!reset) begin
      m_stall = 1'b0;
      m_stalls = 0;
      m_flushes = 0;
    end else begin
      bit r, lu;
      r  = m_redirect();
      lu = m_load_use();
      if (r) m_flushes++;
      else if (lu) m_stalls++;
      m_stall = lu && !r;
    end
  end

  always @(posedge clk) begin
    #3;
    if (reset) begin
      bit r, lu;
      logic [3:0] ec;
      r  = m_redirect();
      lu = m_load_use();
      ec = {!(lu && !r), !(lu && !r), r, r || lu};
      chk("fields_a", 128'(flds_a), 128'(bus));
      chk("fields_b", 128'(flds_b), 128'(bus));
      chk("ctrl_a", 128'(ctrl_a), 128'(ec));
      chk("ctrl_b", 128'(ctrl_b), 128'(ec));
      chk("stall_cnt_a", 128'(if_a.stall_count), 128'(sat(m_stalls, W_A)));
      chk("flush_cnt_a", 128'(if_a.flush_count), 128'(sat(m_flushes, W_A)));
      chk("stall_cnt_b", 128'(if_b.stall_count), 128'(sat(m_stalls, W_B)));
      chk("flush_cnt_b", 128'(if_b.flush_count), 128'(sat(m_flushes, W_B)));
    end
  end

  function automatic logic [115:0] mk(input bit mr, input logic [4:0] rdv,
                                      input bit br, input bit jl, input bit jr);
    logic [115:0] v;
    v = '0;
    v[31:0]   = 32'hA5A5_0F0F;
    v[95:64]  = 32'h1234_5678;
    v[107]    = mr;
    v[100:96] = rdv;
    v[110]    = br;
    v[108]    = jl;
    v[109]    = jr;
    return v;
  endfunction

  task automatic drive(input logic [115:0] b, input logic [4:0] r1, input logic [4:0] r2,
                       input logic u, input logic t);
    @(posedge clk);
    #1;
    bus = b; rs1 = r1; rs2 = r2; uses = u; taken = t;
  endtask

  initial begin
    logic [115:0] v;
    #2;
    chk("rst_ctrl_a", 128'(ctrl_a), 128'(4'b1100));
    chk("rst_ctrl_b", 128'(ctrl_b), 128'(4'b1100));
    chk("rst_stall_a", 128'(if_a.stall_count), 128'd0);
    chk("rst_flush_a", 128'(if_a.flush_count), 128'd0);
    @(posedge clk); #1 reset = 1'b1;

    // load-use on rs1: one stall cycle, then release with the same inputs
    drive(mk(1, 5, 0, 0, 0), 5, 0, 0, 0); #3 chk("t1_stall", 128'(ctrl_a), 128'(4'b0001));
    drive(mk(1, 5, 0, 0, 0), 5, 0, 0, 0); #3 chk("t1_release", 128'(ctrl_a), 128'(4'b1100));
    drive('0, 0, 0, 0, 0); #3 chk("t1_count", 128'(if_a.stall_count), 128'd1);

    // rs2 dependence only when rs2 is actually read
    drive(mk(1, 5, 0, 0, 0), 0, 5, 0, 0); #3 chk("t2_no_rs2", 128'(ctrl_a), 128'(4'b1100));
    drive(mk(1, 5, 0, 0, 0), 0, 5, 1, 0); #3 chk("t2_rs2", 128'(ctrl_a), 128'(4'b0001));
    drive('0, 0, 0, 0, 0); #3 chk("t2_count", 128'(if_a.stall_count), 128'd2);

    // x0 destination never stalls
    drive(mk(1, 0, 0, 0, 0), 0, 0, 1, 0); #3 chk("t3_x0", 128'(ctrl_a), 128'(4'b1100));
    drive('0, 0, 0, 0, 0); #3 chk("t3_count", 128'(if_a.stall_count), 128'd2);

    // redirects, taken branch outranks a simultaneous load-use
    drive(mk(1, 5, 1, 0, 0), 5, 0, 0, 1); #3 chk("t4_br", 128'(ctrl_a), 128'(4'b1111));
    drive(mk(0, 0, 0, 1, 0), 0, 0, 0, 0); #3 chk("t4_jal", 128'(ctrl_a), 128'(4'b1111));
    chk("t4_flush1", 128'(if_a.flush_count), 128'd1);
    drive(mk(0, 0, 0, 0, 1), 0, 0, 0, 0); #3 chk("t4_jalr", 128'(ctrl_a), 128'(4'b1111));
    drive(mk(0, 0, 1, 0, 0), 0, 0, 0, 0); #3 chk("t4_not_taken", 128'(ctrl_a), 128'(4'b1100));
    chk("t4_flush3", 128'(if_a.flush_count), 128'd3);
    chk("t4_stall", 128'(if_a.stall_count), 128'd2);

    // walking one across the whole bus
    for (int i = 0; i < 116; i++) begin
      v = '0;
      v[i] = 1'b1;
      drive(v, 31, 31, 1, 0);
      #3;
      if (i == 0)   chk("walk_imm", 128'(if_a.imm), 128'd1);
      if (i == 100) chk("walk_rd", 128'(if_a.rd), 128'(5'b10000));
      if (i == 115) chk("walk_func7", 128'(if_a.func7), 128'd1);
    end
    drive('0, 0, 0, 0, 0);

    // asynchronous reset while in the stall cycle
    drive(mk(1, 5, 0, 0, 0), 5, 0, 0, 0);
    @(posedge clk); #1;
    reset = 1'b0; bus = '0;
    #1;
    chk("t6_rst_ctrl", 128'(ctrl_a), 128'(4'b1100));
    chk("t6_rst_stall_a", 128'(if_a.stall_count), 128'd0);
    chk("t6_rst_flush_b", 128'(if_b.flush_count), 128'd0);
    bus = mk(1, 5, 0, 0, 0);
    #1 chk("t6_back_to_run", 128'(ctrl_a), 128'(4'b0001));
    bus = '0;
    @(posedge clk); #1 reset = 1'b1;

    // saturation of the narrow counters
    repeat (5) begin
      drive(mk(1, 5, 0, 0, 0), 5, 0, 0, 0);
      drive('0, 0, 0, 0, 0);
    end
    #3;
    chk("t6_sat_b", 128'(if_b.stall_count), 128'd3);
    chk("t6_full_a", 128'(if_a.stall_count), 128'd5);

    drive('0, 0, 0, 0, 0);
    @(posedge clk); #5;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
